// File: rtl/decoder_if.sv
// Stream bundle for the 64b/66b block decoder.
//   encoded_*      : upstream 66-bit block stream (valid/ready)
//   xgmii_*        : downstream XGMII beat stream, one half-word per beat
// Modports:
//   slave  : the decoder's view (consumes blocks, produces XGMII beats)
//   master : the environment's view (produces blocks, consumes beats)
interface decoder_if #(
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int XGMII_DATA_BYTES = XGMII_DATA_WIDTH / 8,
  parameter int PCS_DATA_WIDTH   = 66
);
  logic [PCS_DATA_WIDTH-1:0]   encoded_data_in;
  logic                        encoded_valid_in;
  logic                        encoded_ready_out;
  logic [XGMII_DATA_WIDTH-1:0] xgmii_data_out;
  logic [XGMII_DATA_BYTES-1:0] xgmii_ctrl_out;
  logic                        xgmii_valid_out;
  logic                        xgmii_ready_in;

  modport slave (
    input  encoded_data_in, encoded_valid_in, xgmii_ready_in,
    output encoded_ready_out, xgmii_data_out, xgmii_ctrl_out, xgmii_valid_out
  );

  modport master (
    output encoded_data_in, encoded_valid_in, xgmii_ready_in,
    input  encoded_ready_out, xgmii_data_out, xgmii_ctrl_out, xgmii_valid_out
  );
endinterface

// File: rtl/decoder.sv
// 64b/66b block decoder to a 32-bit XGMII beat stream.
// Each accepted 66-bit block is decoded into a 64-bit data word and an 8-bit
// control word, then presented as two XGMII beats: lanes 0-3, then lanes 4-7.
// Ports:
//   clk          : clock, all state on the rising edge
//   rst          : asynchronous active-low reset
//   bus          : decoder_if.slave (block input stream, XGMII output stream)
//   decode_error : one-cycle pulse after a rejected block is accepted
//   error_count  : saturating count of rejected blocks
module decoder #(
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int XGMII_DATA_BYTES = XGMII_DATA_WIDTH / 8,
  parameter int PCS_DATA_WIDTH   = 66
) (
  input  logic        clk,
  input  logic        rst,
  decoder_if.slave    bus,
  output logic        decode_error,
  output logic [15:0] error_count
);

  typedef enum logic [1:0] {EMPTY, LOW, HIGH} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ctrl;
    logic        err;
  } dec_t;

  state_t      state_q, state_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        enc_ready;
  logic        accept;
  dec_t        dec;

  // Terminate block types map to the lane holding the terminate character.
  // Returns -1 for anything that is not a terminate type.
  function automatic int term_lane(input logic [7:0] btype);
    case (btype)
      8'h87:   return 0;
      8'h99:   return 1;
      8'hAA:   return 2;
      8'hB4:   return 3;
      8'hCC:   return 4;
      8'hD2:   return 5;
      8'hE1:   return 6;
      8'hFF:   return 7;
      default: return -1;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Anything not explicitly recognised falls through to the all-error word.
  function automatic dec_t decode_block(input logic [PCS_DATA_WIDTH-1:0] blk);
    logic [1:0]  sync;
    logic [7:0]  btype;
    logic [55:0] pl;
    int          n;
    dec_t        r;
    sync   = blk[PCS_DATA_WIDTH-1 -: 2];
    btype  = blk[63:56];
    pl     = blk[55:0];
    n      = term_lane(btype);
    r.data = {8{8'hFE}};
    r.ctrl = 8'hFF;
    r.err  = 1'b1;
    if (sync == 2'b01) begin
      r.data = blk[63:0];
      r.ctrl = 8'h00;
      r.err  = 1'b0;
    end else if (sync == 2'b10) begin
      if (btype == 8'h78) begin
        r.data = {pl, 8'hFB};
        r.ctrl = 8'h01;
        r.err  = 1'b0;
      end else if (btype == 8'h33) begin
        r.data = {pl[31:0], pl[55:32], 8'h07};
        r.ctrl = 8'h1F;
        r.err  = 1'b0;
      end else if (btype == 8'h1E) begin
        // A control block with non-idle content is replaced by errors on
        // the lanes but is not counted as a rejected block.
        r.err = 1'b0;
        if (pl == {7{8'h07}}) r.data = {8{8'h07}};
      end else if (n >= 0) begin
        // Terminate in lane n: the top n payload bytes fill lanes below it.
        r.err = 1'b0;
        for (int k = 0; k < 8; k++) begin
          if (k < n)       r.data[8*k +: 8] = pl[8*(7-n+k) +: 8];
          else if (k == n) r.data[8*k +: 8] = 8'hFD;
          else             r.data[8*k +: 8] = 8'h07;
          r.ctrl[k] = (k >= n);
        end
      end
    end
    return r;
  endfunction

  // A new block can enter while the last beat of the previous one leaves,
  // so consecutive blocks stream without a bubble.
  always_comb begin
    enc_ready = rst & ((state_q == EMPTY) | ((state_q == HIGH) & bus.xgmii_ready_in));
    accept    = bus.encoded_valid_in & enc_ready;
    dec       = decode_block(bus.encoded_data_in);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = LOW;
      LOW:   if (bus.xgmii_ready_in) state_d = HIGH;
      HIGH:  if (bus.xgmii_ready_in) state_d = accept ? LOW : EMPTY;
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      data_d = dec.data;
      ctrl_d = dec.ctrl;
      err_d  = dec.err;
      if (dec.err) cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ctrl_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output lanes are zero while no beat is being presented.
  always_comb begin
    bus.encoded_ready_out = enc_ready;
    bus.xgmii_valid_out   = (state_q != EMPTY);
    bus.xgmii_data_out    = '0;
    bus.xgmii_ctrl_out    = '0;
    if (state_q == LOW) begin
      bus.xgmii_data_out = data_q[0 +: XGMII_DATA_WIDTH];
      bus.xgmii_ctrl_out = ctrl_q[0 +: XGMII_DATA_BYTES];
    end else if (state_q == HIGH) begin
      bus.xgmii_data_out = data_q[XGMII_DATA_WIDTH +: XGMII_DATA_WIDTH];
      bus.xgmii_ctrl_out = ctrl_q[XGMII_DATA_BYTES +: XGMII_DATA_BYTES];
    end
    decode_error = err_q;
    error_count  = cnt_q;
  end

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for the 64b/66b decoder: directed blocks, a randomized
// stream with random downstream stalls, and an asynchronous reset mid-block.
module tb_decoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        decode_error;
  logic [15:0] error_count;

  always #5 clk = ~clk;

  decoder_if ifc ();

  decoder dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (ifc),
    .decode_error (decode_error),
    .error_count  (error_count)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  c;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by main

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Reference decode built lane by lane from the block rules.
  function automatic void model(input logic [65:0] blk, output logic [63:0] d,
                                output logic [7:0] c, output bit e);
    logic [7:0]  p[7];
    logic [7:0]  lane[8];
    logic [7:0]  tcode[8];
    logic [7:0]  t;
    logic [55:0] pl;
    bit          idle;
    int          n;
    tcode = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    t  = blk[63:56];
    pl = blk[55:0];
    for (int i = 0; i < 7; i++) p[i] = pl[8*i +: 8];
    for (int i = 0; i < 8; i++) lane[i] = 8'hFE;
    c = 8'hFF;
    e = 1'b1;
    n = -1;
    for (int i = 0; i < 8; i++) if (tcode[i] == t) n = i;
    if (blk[65:64] == 2'b10) begin
      if (t == 8'h78) begin
        lane[0] = 8'hFB;
        for (int i = 1; i < 8; i++) lane[i] = p[i-1];
        c = 8'h01; e = 1'b0;
      end else if (t == 8'h33) begin
        lane[0] = 8'h07;
        lane[1] = p[4]; lane[2] = p[5]; lane[3] = p[6];
        for (int i = 4; i < 8; i++) lane[i] = p[i-4];
        c = 8'h1F; e = 1'b0;
      end else if (t == 8'h1E) begin
        e = 1'b0;
        idle = 1'b1;
        for (int i = 0; i < 7; i++) if (p[i] != 8'h07) idle = 1'b0;
        if (idle) for (int i = 0; i < 8; i++) lane[i] = 8'h07;
      end else if (n >= 0) begin
        e = 1'b0;
        for (int j = 0; j < 8; j++)
          lane[j] = (j < n) ? p[7-n+j] : ((j == n) ? 8'hFD : 8'h07);
        c = 8'hFF << n;
      end
    end
    for (int i = 0; i < 8; i++) d[8*i +: 8] = lane[i];
    if (blk[65:64] == 2'b01) begin
      d = blk[63:0];
      c = 8'h00;
      e = 1'b0;
    end
  endfunction

  task automatic push_expected(input logic [65:0] blk);
    logic [63:0] d;
    logic [7:0]  c;
    bit          e;
    beat_t       b;
    model(blk, d, c, e);
    b.d = d[31:0];  b.c = c[3:0]; exp_q.push_back(b);
    b.d = d[63:32]; b.c = c[7:4]; exp_q.push_back(b);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_block(input logic [65:0] blk, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    ifc.encoded_data_in  = blk;
    ifc.encoded_valid_in = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (ifc.encoded_ready_out) begin
        push_expected(blk);
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
      if (!done && waits > 200) begin
        check("accept_timeout", 64'(waits), 64'd0);
        done = 1'b1;
      end
    end
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    ifc.encoded_valid_in = 1'b0;
    while (exp_q.size() != 0 && cyc < 300) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [65:0] rand_block();
    logic [7:0]  good[11];
    logic [63:0] r;
    logic [1:0]  s;
    int          k;
    good = '{8'h78, 8'h33, 8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF, 8'h1E};
    r = {$urandom, $urandom};
    k = $urandom_range(0, 9);
    if (k < 4) return {2'b01, r};
    if (k < 8) return {2'b10, good[$urandom_range(0, 10)], r[55:0]};
    if (k == 8) return {2'b10, 8'h1E, {7{8'h07}}};
    if ($urandom_range(0, 2) == 0) return {2'b10, r};
    s = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    return {s, r};
  endfunction

  // Downstream ready generator.
  initial begin
    ifc.xgmii_ready_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0)      ifc.xgmii_ready_in = 1'b1;
      else if (rdy_mode == 1) ifc.xgmii_ready_in = ($urandom_range(0, 9) < 6);
    end
  end

  // Output monitor: pops the scoreboard on every transferred beat and checks
  // that a stalled beat does not change.
  bit          prev_stall = 1'b0;
  logic [31:0] held_d;
  logic [3:0]  held_c;
  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && ifc.xgmii_valid_out) begin
        check("stall_hold_data", 64'(ifc.xgmii_data_out), 64'(held_d));
        check("stall_hold_ctrl", 64'(ifc.xgmii_ctrl_out), 64'(held_c));
      end
      if (ifc.xgmii_valid_out && ifc.xgmii_ready_in) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(ifc.xgmii_data_out), 64'hDEAD_BEEF_0000_0000);
        end else begin
          b = exp_q.pop_front();
          check("beat_data", 64'(ifc.xgmii_data_out), 64'(b.d));
          check("beat_ctrl", 64'(ifc.xgmii_ctrl_out), 64'(b.c));
        end
      end
      prev_stall = ifc.xgmii_valid_out && !ifc.xgmii_ready_in;
      held_d = ifc.xgmii_data_out;
      held_c = ifc.xgmii_ctrl_out;
    end
  end

  // Error pulse / counter checker, tracks accepts on its own.
  bit          exp_err = 1'b0;
  logic [15:0] exp_cnt = 16'd0;
  always @(negedge clk) begin
    logic [63:0] d;
    logic [7:0]  c;
    bit          e;
    if (!rst) begin
      exp_err = 1'b0;
      exp_cnt = 16'd0;
    end else begin
      check("decode_error", 64'(decode_error), 64'(exp_err));
      check("error_count", 64'(error_count), 64'(exp_cnt));
      model(ifc.encoded_data_in, d, c, e);
      exp_err = ifc.encoded_valid_in && ifc.encoded_ready_out && e;
      if (exp_err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [7:0] tt[8];
    tt = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    rst = 1'b0;
    ifc.encoded_valid_in = 1'b0;
    ifc.encoded_data_in  = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", 64'(ifc.xgmii_valid_out), 64'd0);
    check("rst_ready", 64'(ifc.encoded_ready_out), 64'd0);
    check("rst_data", 64'(ifc.xgmii_data_out), 64'd0);
    check("rst_ctrl", 64'(ifc.xgmii_ctrl_out), 64'd0);
    check("rst_err", 64'(decode_error), 64'd0);
    check("rst_cnt", 64'(error_count), 64'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;

    // Two rejected blocks straight after reset.
    rdy_mode = 0;
    send_block({2'b11, 64'h0123_4567_89AB_CDEF}, w);
    send_block({2'b10, 8'h55, 56'h11_2233_4455_6677}, w);
    drain();
    repeat (2) @(posedge clk);
    #1;
    check("err_count_two", 64'(error_count), 64'd2);

    // Back-to-back data blocks: each follow-on block waits exactly one cycle.
    for (int i = 0; i < 4; i++) begin
      send_block({2'b01, 64'h0706_0504_0302_0100}, w);
      if (i > 0) check("b2b_waits", 64'(w), 64'd1);
    end
    drain();

    // Start, S4, terminates with a ramp payload, idle and non-idle control.
    send_block({2'b10, 8'h78, 56'hD6_D5D4_D3D2_D1D0}, w);
    send_block({2'b10, 8'h33, 56'h16_1514_1312_1110}, w);
    for (int n = 0; n < 8; n++) send_block({2'b10, tt[n], 56'h37_3635_3433_3231}, w);
    send_block({2'b10, 8'h1E, {7{8'h07}}}, w);
    send_block({2'b10, 8'h1E, 56'h07_0707_0707_0700}, w);
    send_block({2'b00, 64'h0}, w);
    drain();

    // Random stream with random downstream stalls and input gaps.
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      send_block(rand_block(), w);
      if ($urandom_range(0, 3) == 0) begin
        ifc.encoded_valid_in = 1'b0;
        @(posedge clk); #1;
      end
    end
    drain();

    // Reset while the high half is stalled.
    @(posedge clk); #1;
    rdy_mode = 2;
    ifc.xgmii_ready_in = 1'b0;
    send_block({2'b01, 64'hAAAA_BBBB_CCCC_DDDD}, w);
    ifc.encoded_valid_in = 1'b0;
    ifc.xgmii_ready_in = 1'b1;
    @(posedge clk); #1;
    ifc.xgmii_ready_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ifc.xgmii_ready_in = 1'b1;
    exp_q.delete();
    #1;
    check("arst_valid", 64'(ifc.xgmii_valid_out), 64'd0);
    check("arst_ready", 64'(ifc.encoded_ready_out), 64'd0);
    check("arst_data", 64'(ifc.xgmii_data_out), 64'd0);
    check("arst_ctrl", 64'(ifc.xgmii_ctrl_out), 64'd0);
    check("arst_err", 64'(decode_error), 64'd0);
    check("arst_cnt", 64'(error_count), 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk); #1;
    rdy_mode = 0;
    send_block({2'b10, 8'h78, 56'h66_5544_3322_1100}, w);
    drain();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
